// File: rtl/fb_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_writer_if : draw-request handshake and framebuffer write bus of fb_writer
// Rev 1.0
// ---------------------------------------------------------------------------
interface fb_writer_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_cmd;
   logic [9:0]  req_x;
   logic [9:0]  req_y;
   logic [9:0]  req_w;
   logic [9:0]  req_h;
   logic [23:0] req_rgb;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [23:0] fb_wdata;
   logic        busy;
   logic [7:0]  err_cnt;

   modport master (
      output req_valid, req_cmd, req_x, req_y, req_w, req_h, req_rgb,
      input  req_ready, fb_we, fb_addr, fb_wdata, busy, err_cnt
   );

   modport slave (
      input  req_valid, req_cmd, req_x, req_y, req_w, req_h, req_rgb,
      output req_ready, fb_we, fb_addr, fb_wdata, busy, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_writer : single-pixel and clipped rectangle-fill writer for the framebuffer
// Rev 1.0
// ---------------------------------------------------------------------------
module fb_writer #(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  wire logic   clk,
   input  wire logic   reset,
   fb_writer_if.slave  bus
);

   localparam logic [10:0] H_LIM = 11'(H_RES);
   localparam logic [10:0] V_LIM = 11'(V_RES);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  x0_q, x0_d;
   logic [9:0]  cx_q, cx_d;
   logic [9:0]  cy_q, cy_d;
   logic [10:0] xe_q, xe_d;
   logic [10:0] ye_q, ye_d;
   logic [23:0] rgb_q, rgb_d;
   logic        we_q, we_d;
   logic [18:0] addr_q, addr_d;
   logic [23:0] wdata_q, wdata_d;
   logic [7:0]  err_q, err_d;

   logic        w_accept;
   logic        w_in_range;
   logic [10:0] w_xsum, w_ysum;
   logic [10:0] w_xe_clip, w_ye_clip;
   logic [10:0] w_x_next, w_y_next;
   logic        w_row_end, w_last;
   logic [9:0]  w_nx, w_ny;

   // Row stride is fixed at 640 words: y*640 = (y<<9) + (y<<7)
   function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
      return ({9'd0, y} << 9) + ({9'd0, y} << 7) + {9'd0, x};
   endfunction

   assign w_accept   = bus.req_valid && (state_q == S_IDLE);
   assign w_in_range = ({1'b0, bus.req_x} < H_LIM) && ({1'b0, bus.req_y} < V_LIM);
   assign w_xsum     = {1'b0, bus.req_x} + {1'b0, bus.req_w};
   assign w_ysum     = {1'b0, bus.req_y} + {1'b0, bus.req_h};
   assign w_xe_clip  = (w_xsum > H_LIM) ? H_LIM : w_xsum;
   assign w_ye_clip  = (w_ysum > V_LIM) ? V_LIM : w_ysum;

   // Fill walk: cx_q/cy_q name the pixel being written in the current cycle
   assign w_x_next  = {1'b0, cx_q} + 11'd1;
   assign w_y_next  = {1'b0, cy_q} + 11'd1;
   assign w_row_end = (w_x_next == xe_q);
   assign w_last    = w_row_end && (w_y_next == ye_q);
   assign w_nx      = w_row_end ? x0_q : w_x_next[9:0];
   assign w_ny      = w_row_end ? w_y_next[9:0] : cy_q;

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      rgb_d   = rgb_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_in_range) begin
                  err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
               end else if (!bus.req_cmd) begin
                  we_d    = 1'b1;
                  addr_d  = pix_addr(bus.req_x, bus.req_y);
                  wdata_d = bus.req_rgb;
               end else if ((bus.req_w != 10'd0) && (bus.req_h != 10'd0)) begin
                  we_d    = 1'b1;
                  addr_d  = pix_addr(bus.req_x, bus.req_y);
                  wdata_d = bus.req_rgb;
                  rgb_d   = bus.req_rgb;
                  x0_d    = bus.req_x;
                  cx_d    = bus.req_x;
                  cy_d    = bus.req_y;
                  xe_d    = w_xe_clip;
                  ye_d    = w_ye_clip;
                  state_d = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (w_last) begin
               state_d = S_IDLE;
            end else begin
               cx_d    = w_nx;
               cy_d    = w_ny;
               we_d    = 1'b1;
               addr_d  = pix_addr(w_nx, w_ny);
               wdata_d = rgb_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         x0_q    <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         xe_q    <= '0;
         ye_q    <= '0;
         rgb_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         rgb_q   <= rgb_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q == S_FILL);
   assign bus.fb_we     = we_q;
   assign bus.fb_addr   = addr_q;
   assign bus.fb_wdata  = wdata_q;
   assign bus.err_cnt   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fb_writer : directed and randomized self-checking bench for fb_writer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fb_writer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fb_writer_if bus();

   fb_writer #(.H_RES(640), .V_RES(480)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int exp_err = 0;
   logic [42:0] exp_q[$];
   logic [42:0] obs_q[$];
   logic mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en && bus.fb_we === 1'b1)
         obs_q.push_back({bus.fb_addr, bus.fb_wdata});
   end

   task automatic set_req(input int cmd, input int x, input int y,
                          input int w, input int h, input logic [23:0] rgb);
      bus.req_valid = 1'b1;
      bus.req_cmd   = cmd[0];
      bus.req_x     = 10'(x);
      bus.req_y     = 10'(y);
      bus.req_w     = 10'(w);
      bus.req_h     = 10'(h);
      bus.req_rgb   = rgb;
   endtask

   // Reference: every accepted request expands to its list of pixel writes
   task automatic model_req(input int cmd, input int x, input int y,
                            input int w, input int h, input logic [23:0] rgb);
      if (x >= 640 || y >= 480) begin
         if (exp_err < 255) exp_err++;
      end else if (cmd == 0) begin
         exp_q.push_back({19'(y * 640 + x), rgb});
      end else if (w != 0 && h != 0) begin
         int xe = (x + w > 640) ? 640 : x + w;
         int ye = (y + h > 480) ? 480 : y + h;
         for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++)
               exp_q.push_back({19'(yy * 640 + xx), rgb});
      end
   endtask

   task automatic send(input int cmd, input int x, input int y,
                       input int w, input int h, input logic [23:0] rgb);
      int n = 0;
      set_req(cmd, x, y, w, h, rgb);
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 1000) begin
         errors++;
         $display("FAIL send_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
      end
      @(posedge clk);
      model_req(cmd, x, y, w, h, rgb);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      bus.req_valid = 1'b0;
      set_req(0, 0, 0, 0, 0, 24'h0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      checks += 6;
      if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.fb_we); end
      if (bus.fb_addr !== 19'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.fb_addr); end
      if (bus.fb_wdata !== 24'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.fb_wdata); end
      if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", bus.err_cnt); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Starts right after reset release so the first edge accepts the request
   task automatic test_pixel;
      set_req(0, 5, 2, 0, 0, 24'hFF0000);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      checks += 3;
      if (bus.fb_we !== 1'b1) begin errors++; $display("FAIL pixel_we: got %b want 1", bus.fb_we); end
      if (bus.fb_addr !== 19'd1285) begin errors++; $display("FAIL pixel_addr: got %0d want 1285", bus.fb_addr); end
      if (bus.fb_wdata !== 24'hFF0000) begin errors++; $display("FAIL pixel_wdata: got %h want ff0000", bus.fb_wdata); end
      @(negedge clk);
      checks += 3;
      if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL pixel_we_off: got %b want 0", bus.fb_we); end
      if (bus.fb_addr !== 19'd1285) begin errors++; $display("FAIL pixel_addr_hold: got %0d want 1285", bus.fb_addr); end
      if (bus.fb_wdata !== 24'hFF0000) begin errors++; $display("FAIL pixel_wdata_hold: got %h want ff0000", bus.fb_wdata); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      int xs[3] = '{0, 639, 1};
      int ys[3] = '{0, 479, 0};
      int ad[3] = '{0, 307199, 1};
      for (int i = 0; i < 3; i++) begin
         set_req(0, xs[i], ys[i], 0, 0, 24'h123456 + 24'(i));
         @(posedge clk);
         #1 if (i == 2) bus.req_valid = 1'b0;
         @(negedge clk);
         checks += 4;
         if (bus.fb_we !== 1'b1) begin errors++; $display("FAIL b2b_we[%0d]: got %b want 1", i, bus.fb_we); end
         if (bus.fb_addr !== 19'(ad[i])) begin errors++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, bus.fb_addr, ad[i]); end
         if (bus.fb_wdata !== 24'h123456 + 24'(i)) begin errors++; $display("FAIL b2b_wdata[%0d]: got %h", i, bus.fb_wdata); end
         if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.req_ready); end
         if (i < 2) begin @(posedge clk); #1; end
      end
      @(negedge clk);
      checks++;
      if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL b2b_we_off: got %b want 0", bus.fb_we); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill_clip;
      int ad[4] = '{306558, 306559, 307198, 307199};
      set_req(1, 638, 478, 4, 4, 24'h00FF00);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks += 5;
         if (bus.fb_we !== 1'b1) begin errors++; $display("FAIL fill_we[%0d]: got %b want 1", i, bus.fb_we); end
         if (bus.fb_addr !== 19'(ad[i])) begin errors++; $display("FAIL fill_addr[%0d]: got %0d want %0d", i, bus.fb_addr, ad[i]); end
         if (bus.fb_wdata !== 24'h00FF00) begin errors++; $display("FAIL fill_wdata[%0d]: got %h want 00ff00", i, bus.fb_wdata); end
         if (bus.busy !== 1'b1) begin errors++; $display("FAIL fill_busy[%0d]: got %b want 1", i, bus.busy); end
         if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready[%0d]: got %b want 0", i, bus.req_ready); end
      end
      @(negedge clk);
      checks += 3;
      if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL fill_end_we: got %b want 0", bus.fb_we); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL fill_end_busy: got %b want 0", bus.busy); end
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL fill_end_ready: got %b want 1", bus.req_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_errors;
      int we_seen = 0;
      set_req(0, 640, 0, 0, 0, 24'hABCDEF);
      @(posedge clk);
      #1 set_req(1, 0, 480, 5, 5, 24'hABCDEF);
      @(negedge clk);
      if (bus.fb_we === 1'b1) we_seen++;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      if (bus.fb_we === 1'b1) we_seen++;
      checks += 2;
      if (bus.err_cnt !== 8'd2) begin errors++; $display("FAIL err_two: got %0d want 2", bus.err_cnt); end
      if (we_seen != 0) begin errors++; $display("FAIL err_no_write: got %0d writes want 0", we_seen); end
      @(posedge clk);
      #1;
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) set_req(0, $urandom_range(640, 1023), $urandom_range(0, 479), 0, 0, 24'h1);
         else            set_req(0, $urandom_range(0, 639), $urandom_range(480, 1023), 0, 0, 24'h1);
         @(posedge clk);
         #1;
         if (bus.fb_we === 1'b1) we_seen++;
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      checks += 2;
      if (bus.err_cnt !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d want 255", bus.err_cnt); end
      if (we_seen != 0) begin errors++; $display("FAIL err_burst_write: got %0d writes want 0", we_seen); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_abort;
      int writes = 0;
      int after = 0;
      int n = 0;
      reset = 1'b0;
      #3 reset = 1'b1;
      @(posedge clk);
      #1 set_req(1, 0, 0, 10, 10, 24'h0000FF);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      while (writes < 5 && n < 50) begin
         @(negedge clk);
         n++;
         if (bus.fb_we === 1'b1) begin
            checks++;
            if (bus.fb_addr !== 19'(writes)) begin errors++; $display("FAIL abort_addr[%0d]: got %0d want %0d", writes, bus.fb_addr, writes); end
            writes++;
         end
      end
      checks++;
      if (writes != 5) begin errors++; $display("FAIL abort_prefix: got %0d writes want 5", writes); end
      reset = 1'b0;
      #1;
      checks += 4;
      if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL abort_we: got %b want 0", bus.fb_we); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", bus.req_ready); end
      if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL abort_err: got %0d want 0", bus.err_cnt); end
      @(posedge clk);
      #2 reset = 1'b1;
      repeat (120) begin
         @(negedge clk);
         if (bus.fb_we === 1'b1) after++;
      end
      checks++;
      if (after != 0) begin errors++; $display("FAIL abort_resume: got %0d writes want 0", after); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero_size;
      set_req(1, 10, 10, 0, 7, 24'hFFFFFF);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            bus.req_w = 10'd5;
            bus.req_h = 10'd0;
         end
         @(negedge clk);
         checks += 3;
         if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL zero_we[%0d]: got %b want 0", i, bus.fb_we); end
         if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready[%0d]: got %b want 1", i, bus.req_ready); end
         if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL zero_err[%0d]: got %0d want 0", i, bus.err_cnt); end
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic test_random;
      int n = 0;
      int cmd, x, y, w, h;
      exp_err = 0;
      exp_q.delete();
      obs_q.delete();
      mon_en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         cmd = $urandom_range(0, 1);
         case ($urandom_range(0, 5))
            0:       x = $urandom_range(640, 1023);
            1, 2:    x = $urandom_range(625, 639);
            default: x = $urandom_range(0, 639);
         endcase
         case ($urandom_range(0, 5))
            0:       y = $urandom_range(480, 1023);
            1, 2:    y = $urandom_range(468, 479);
            default: y = $urandom_range(0, 479);
         endcase
         w = $urandom_range(0, 14);
         h = $urandom_range(0, 10);
         send(cmd, x, y, w, h, 24'($urandom));
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      while (bus.busy === 1'b1 && n < 1000) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      checks += 2;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
      if (bus.err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL rand_err: got %0d want %0d", bus.err_cnt, exp_err); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_write[%0d]: got addr %0d data %h want addr %0d data %h",
                     i, obs_q[i][42:24], obs_q[i][23:0], exp_q[i][42:24], exp_q[i][23:0]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_pixel();
      test_back_to_back();
      test_fill_clip();
      test_errors();
      test_reset_abort();
      test_zero_size();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter H_RES, default 640, sets visible pixels per line.
REQ-002 Parameter V_RES, default 480, sets visible lines per frame.
REQ-003 clk  input  1  pixel/system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  a draw request is present.
REQ-006 req_ready  output  1  the block accepts a request this cycle.
REQ-007 req_cmd  input  1  request type: 0 = single pixel, 1 = rectangle fill.
REQ-008 req_x, req_y  input  10 each  pixel or rectangle origin.
REQ-009 req_w, req_h  input  10 each  fill width and height; ignored for pixel requests.
REQ-010 req_rgb  input  24  colour as {R[7:0], G[7:0], B[7:0]}.
REQ-011 fb_we  output  1  framebuffer write strobe, one pixel per cycle.
REQ-012 fb_addr  output  19  framebuffer word address.
REQ-013 fb_wdata  output  24  framebuffer write data.
REQ-014 busy  output  1  a fill is in progress.
REQ-015 err_cnt  output  8  count of rejected requests, saturating.

Function
REQ-016 The block shall be the write-side producer for the 24-bit framebuffer read by the VGA controller, with fb_addr = y*640 + x computed as (y<<9) + (y<<7) + x in 19 bits.
REQ-017 A request shall be accepted on a rising edge where req_valid and req_ready are both 1; all req_* fields shall be sampled at that edge only.
REQ-018 The FSM shall have two states, IDLE and FILL; req_ready = 1 in IDLE and 0 in FILL; busy = 1 exactly in FILL.
REQ-019 Pixel request, x < H_RES and y < V_RES: in the cycle after acceptance, fb_we = 1, fb_addr = address(x, y), fb_wdata = rgb; the state shall remain IDLE so back-to-back pixels sustain one write per cycle.
REQ-020 Pixel request, x >= H_RES or y >= V_RES: no write, and err_cnt shall increment by 1 in the cycle after acceptance.
REQ-021 Fill request, origin in range, w != 0 and h != 0: enter FILL and clip the end points to xe = min(x+w, H_RES) and ye = min(y+h, V_RES), computed with 11-bit sums.
REQ-022 In FILL, the block shall write one pixel per cycle in row-major order, x from origin to xe-1, then y+1 with x reset to the origin, ending at (xe-1, ye-1).
REQ-023 The first fill write shall occur in the cycle after acceptance; a rectangle of N clipped pixels shall produce exactly N consecutive fb_we cycles.
REQ-024 The state shall return to IDLE on the edge that ends the last write cycle, so req_ready = 1 in the following cycle.
REQ-025 Fill with origin out of range: no writes, err_cnt increments by 1, and the state stays IDLE.
REQ-026 Fill with w = 0 or h = 0: no writes, no error increment, and the state stays IDLE.
REQ-027 err_cnt shall saturate at 255 and never wrap.
REQ-028 fb_we shall be 0 in every cycle with no scheduled write; fb_addr and fb_wdata shall hold their last values while fb_we = 0.
REQ-029 All outputs except req_ready and busy shall be registered; req_ready and busy shall decode the state register only.

Reset
REQ-030 When reset is low, the FSM shall enter IDLE immediately and asynchronously, with fb_we = 0, fb_addr = 0, fb_wdata = 0, err_cnt = 0, busy = 0, and req_ready = 1.
REQ-031 Reset asserted during FILL shall abort the fill immediately; no further writes of that fill shall occur after reset is released.
REQ-032 The first request may be accepted on the first rising edge after reset goes high.

Verification
REQ-033 Pixel (x=5, y=2, rgb=0xFF0000) -> one cycle later fb_we=1, fb_addr=1285, fb_wdata=0xFF0000; next cycle fb_we=0.
REQ-034 Three back-to-back pixels at (0,0), (639,479), (1,0) -> fb_we=1 for 3 consecutive cycles, addresses 0, 307199, 1; req_ready stays 1 throughout.
REQ-035 Fill (x=638, y=478, w=4, h=4, rgb=0x00FF00) -> 4 writes at addresses 306558, 306559, 307198, 307199; busy=1 for exactly 4 cycles; req_ready returns to 1 the next cycle.
REQ-036 Pixel (640, 0), then fill with origin (0, 480) -> no fb_we; err_cnt = 2; then 300 invalid pixels -> err_cnt = 255.
REQ-037 Fill (0, 0, w=10, h=10), reset pulsed low after the 5th write -> fb_we=0 and busy=0 at once; no writes after release; err_cnt=0.
REQ-038 Fill with w=0 while req_valid held high -> no writes, err_cnt unchanged, req_ready stays 1.
